dl_sequencer: RTL and testbench

- Sits directly upstream of the ROM/NVRAM download ports in the core, between the HPS ioctl byte stream and every DLROM/NVRAM write port.
- Qualifies, registers and checks each downloaded byte, then drives the shared DLAD/DLDT/DLEN bus.
- Tracks load progress, sequence errors and a running checksum.
- Holds the game core in reset until a complete, error-free image has been received.

---
 rtl/dl_sequencer_pkg.sv | 25 ++
 rtl/dl_sequencer_if.sv | 32 +++
 rtl/dl_sequencer_edge.sv | 31 +++
 rtl/dl_sequencer.sv | 157 +++++++++++++++
 tb/tb_dl_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dl_sequencer_pkg.sv
// Shared definitions for the ROM/NVRAM download sequencer: FSM state
// encoding, image region bases and the default image length.
package dl_sequencer_pkg;

    // Sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAIL  = 3'd4;

    // Region bases inside the downloaded image
    localparam logic [16:0] PRG_BASE = 17'h00000;
    localparam logic [16:0] BG_BASE  = 17'h10000;
    localparam logic [16:0] SP0_BASE = 17'h12000;
    localparam logic [16:0] SP1_BASE = 17'h14000;
    localparam logic [16:0] NV_BASE  = 17'h16000;

    // Image ends after the 256-byte NVRAM block
    localparam logic [16:0] IMGLEN_DEF = NV_BASE + 17'h00100;

    // ioctl index carrying the ROM image
    localparam logic [7:0]  ROMIX_DEF  = 8'h00;

endpackage

// File: rtl/dl_sequencer_if.sv
// HPS ioctl byte stream in, shared DLAD/DLDT/DLEN bus and load status out.
interface dl_sequencer_if #(
    parameter int AW = 17
);
    // ioctl side
    logic          IODL;
    logic [7:0]    IOIX;
    logic          IOWR;
    logic [24:0]   IOAD;
    logic [7:0]    IODT;
    // download bus and status
    logic [AW-1:0] DLAD;
    logic [7:0]    DLDT;
    logic          DLEN;
    logic          DLBUSY;
    logic          DLDONE;
    logic          DLERR;
    logic [15:0]   DLSUM;
    logic          CORERST;

    // Producer of the ioctl stream, consumer of the download bus
    modport master (
        output IODL, IOIX, IOWR, IOAD, IODT,
        input  DLAD, DLDT, DLEN, DLBUSY, DLDONE, DLERR, DLSUM, CORERST
    );

    // The sequencer itself
    modport slave (
        input  IODL, IOIX, IOWR, IOAD, IODT,
        output DLAD, DLDT, DLEN, DLBUSY, DLDONE, DLERR, DLSUM, CORERST
    );
endinterface

// File: rtl/dl_sequencer_edge.sv
// Registers the download-active level and flags its rising/falling edges
// combinationally in the cycle the new level is first seen.
module dl_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;
    logic din_d;

    // Next value simply follows the input level
    always_comb begin
        din_d = din;
    end

    // Previous-cycle level; cleared so a load abandoned by reset restarts cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/dl_sequencer.sv
// Download sequencer: qualifies ioctl bytes for the ROM index, registers them
// onto the shared DLAD/DLDT/DLEN bus, tracks sequence errors and a running
// byte sum, and holds the game core in reset until a clean image is loaded.
module dl_sequencer
    import dl_sequencer_pkg::*;
#(
    parameter logic [7:0]  ROMIX  = ROMIX_DEF,
    parameter logic [16:0] IMGLEN = IMGLEN_DEF,
    parameter int          AW     = 17
) (
    input  logic          DLCL,
    input  logic          RESET,
    dl_sequencer_if.slave bus
);

    logic [2:0]    state_q,   state_d;
    logic [16:0]   exp_q,     exp_d;
    logic [AW-1:0] dlad_q,    dlad_d;
    logic [7:0]    dldt_q,    dldt_d;
    logic          dlen_q,    dlen_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;
    logic [15:0]   sum_q,     sum_d;
    logic          corerst_q, corerst_d;

    logic        iodl_rise;
    logic        iodl_fall;
    logic        byte_wr;
    logic        in_range;
    logic        accept;
    logic        start;
    logic [16:0] ioad_lo;

    // Checksum accumulates modulo 2^16
    function automatic logic [15:0] sum_add(input logic [15:0] sum, input logic [7:0] b);
        return sum + {8'h00, b};
    endfunction

    dl_edge u_edge (
        .clk  (DLCL),
        .rst  (RESET),
        .din  (bus.IODL),
        .rise (iodl_rise),
        .fall (iodl_fall)
    );

    assign byte_wr  = bus.IOWR && (bus.IOIX == ROMIX);
    assign in_range = bus.IOAD < {8'h00, IMGLEN};
    assign accept   = (state_q == ST_LOAD) && byte_wr && in_range;
    assign start    = iodl_rise && (bus.IOIX == ROMIX);
    assign ioad_lo  = bus.IOAD[16:0];

    // Next-state logic for the load FSM, write bus and status flags
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        dlad_d    = dlad_q;
        dldt_d    = dldt_q;
        dlen_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        sum_d     = sum_q;
        corerst_d = corerst_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                // Only a ROM-index download restarts; other indices leave a running core alone
                if (start) begin
                    state_d   = ST_LOAD;
                    exp_d     = PRG_BASE;
                    sum_d     = 16'h0000;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    corerst_d = 1'b1;
                    done_d    = 1'b0;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    // Out-of-order bytes are still written; they only poison the result
                    dlen_d = 1'b1;
                    dlad_d = bus.IOAD[AW-1:0];
                    dldt_d = bus.IODT;
                    exp_d  = ioad_lo + 17'd1;
                    sum_d  = sum_add(sum_q, bus.IODT);
                    if (ioad_lo != exp_q) begin
                        err_d = 1'b1;
                    end
                end else if (byte_wr) begin
                    // ROM-index byte beyond the image: dropped and flagged
                    err_d = 1'b1;
                end
                // A byte arriving with the falling edge is taken above before CHECK
                if (iodl_fall) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                busy_d = 1'b0;
                if ((exp_q == IMGLEN) && !err_q) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    corerst_d = 1'b0;
                end else begin
                    state_d   = ST_FAIL;
                    err_d     = 1'b1;
                    corerst_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any load in progress
    always_ff @(posedge DLCL) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            exp_q     <= 17'h00000;
            dlad_q    <= '0;
            dldt_q    <= 8'h00;
            dlen_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sum_q     <= 16'h0000;
            corerst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            dlad_q    <= dlad_d;
            dldt_q    <= dldt_d;
            dlen_q    <= dlen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sum_q     <= sum_d;
            corerst_q <= corerst_d;
        end
    end

    assign bus.DLAD    = dlad_q;
    assign bus.DLDT    = dldt_q;
    assign bus.DLEN    = dlen_q;
    assign bus.DLBUSY  = busy_q;
    assign bus.DLDONE  = done_q;
    assign bus.DLERR   = err_q;
    assign bus.DLSUM   = sum_q;
    assign bus.CORERST = corerst_q;

endmodule

// File: tb/tb_dl_sequencer.sv
// Bench for dl_sequencer: table of load scenarios, hand-written corner
// sequences and randomized loads, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_dl_sequencer;

    localparam logic [7:0]  ROMIX = 8'h00;
    // Shortened image keeps full loads quick while still covering 0x800/0x1000
    localparam logic [16:0] IMG   = 17'h01020;
    localparam int          IMGI  = 32'h1020;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dl_sequencer_if #(.AW(17)) bus ();

    dl_sequencer #(.ROMIX(ROMIX), .IMGLEN(IMG), .AW(17)) dut (
        .DLCL  (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct { logic [7:0] ix; logic [24:0] addr; logic [7:0] data; int gap; } wr_t;
    typedef struct { logic [16:0] addr; logic [7:0] data; int due; } ex_t;
    typedef struct { int kind; bit fall_last; bit exp_done; } vec_t;

    wr_t  wrq[$];
    ex_t  expq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   dlen_bad = 0;
    int   dlen_seen = 0;
    int   err_bad = 0;
    // transaction-level model state
    int          m_exp;
    logic [15:0] m_sum;
    bit          m_err;
    int          m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Every DLEN must match the next expected write exactly in its due cycle
    always @(posedge clk) begin
        #2;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            if (bus.DLEN !== 1'b1 || bus.DLAD !== expq[0].addr || bus.DLDT !== expq[0].data)
                dlen_bad++;
            dlen_seen++;
            expq.delete(0);
        end else if (bus.DLEN !== 1'b0) begin
            dlen_bad++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_exp = 0; m_sum = 16'h0000; m_err = 1'b0; m_cnt = 0;
        dlen_bad = 0; dlen_seen = 0; err_bad = 0;
    endtask

    // Spec rules: ROM-index bytes inside the image are written one cycle later,
    // summed and must arrive in order; ROM-index bytes beyond it are errors.
    task automatic model_write(input wr_t r);
        ex_t e;
        if (r.ix == ROMIX) begin
            if (int'(r.addr) >= IMGI) begin
                m_err = 1'b1;
            end else begin
                if (int'(r.addr) != m_exp) m_err = 1'b1;
                m_exp = int'(r.addr) + 1;
                m_sum = m_sum + {8'h00, r.data};
                m_cnt++;
                e.addr = r.addr[16:0];
                e.data = r.data;
                e.due  = cyc + 1;
                expq.push_back(e);
            end
        end
    endtask

    task automatic push_wr(input logic [7:0] ix, input int addr, input logic [7:0] data, input int gap);
        wr_t r;
        r.ix = ix; r.addr = 25'(addr); r.data = data; r.gap = gap;
        wrq.push_back(r);
    endtask

    // kinds: 0 full, 1 skip 0x1000, 2 one short, 3 empty, 4 out-of-range byte,
    // 5 repeated address, 6 foreign-index byte interleaved
    task automatic build_seq(input int kind);
        int n;
        wrq.delete();
        n = (kind == 2) ? IMGI - 1 : (kind == 3) ? 0 : IMGI;
        for (int a = 0; a < n; a++) begin
            if (kind == 1 && a == 32'h1000) continue;
            push_wr(ROMIX, a, a[7:0], 0);
            if (kind == 4 && a == 32'h100) push_wr(ROMIX, IMGI, 8'h55, 0);
            if (kind == 5 && a == 32'h10)  push_wr(ROMIX, a, 8'h77, 0);
            if (kind == 6 && a == 32'h20)  push_wr(8'h01, a, 8'hAA, 0);
        end
    endtask

    task automatic apply_load(input bit fall_last, input string tag);
        bit ok;
        model_reset();
        bus.IODL = 1'b1; bus.IOIX = ROMIX;
        step();
        check({tag, "_start_busy"},    32'(bus.DLBUSY),  1);
        check({tag, "_start_corerst"}, 32'(bus.CORERST), 1);
        check({tag, "_start_done"},    32'(bus.DLDONE),  0);
        check({tag, "_start_err"},     32'(bus.DLERR),   0);
        check({tag, "_start_sum"},     32'(bus.DLSUM),   0);
        for (int i = 0; i < wrq.size(); i++) begin
            bus.IOWR = 1'b1; bus.IOIX = wrq[i].ix; bus.IOAD = wrq[i].addr; bus.IODT = wrq[i].data;
            if (fall_last && i == wrq.size() - 1) bus.IODL = 1'b0;
            model_write(wrq[i]);
            step();
            bus.IOWR = 1'b0; bus.IOIX = ROMIX;
            if (bus.DLERR !== m_err) err_bad++;
            repeat (wrq[i].gap) step();
        end
        if (!(fall_last && wrq.size() > 0)) begin
            bus.IODL = 1'b0;
            step();
        end
        check({tag, "_check_busy"}, 32'(bus.DLBUSY), 1);
        step();
        ok = !m_err && (m_exp == IMGI);
        check({tag, "_done"},      32'(bus.DLDONE),  32'(ok));
        check({tag, "_corerst"},   32'(bus.CORERST), 32'(!ok));
        check({tag, "_err"},       32'(bus.DLERR),   32'(!ok));
        check({tag, "_busy"},      32'(bus.DLBUSY),  0);
        check({tag, "_sum"},       32'(bus.DLSUM),   32'(m_sum));
        check({tag, "_dlen_bad"},  dlen_bad,         0);
        check({tag, "_dlen_cnt"},  dlen_seen,        m_cnt);
        check({tag, "_err_track"}, err_bad,          0);
    endtask

    initial begin
        vec_t vt[8];
        wr_t  r;
        int   mode, pos;
        bus.IODL = 1'b0; bus.IOIX = 8'h00; bus.IOWR = 1'b0; bus.IOAD = '0; bus.IODT = 8'h00;

        vt[0] = '{0, 1'b0, 1'b1};
        vt[1] = '{0, 1'b1, 1'b1};
        vt[2] = '{1, 1'b0, 1'b0};
        vt[3] = '{2, 1'b1, 1'b0};
        vt[4] = '{3, 1'b0, 1'b0};
        vt[5] = '{4, 1'b0, 1'b0};
        vt[6] = '{5, 1'b1, 1'b0};
        vt[7] = '{6, 1'b0, 1'b1};

        // reset state
        step(); step();
        check("rst_dlad",    32'(bus.DLAD),    0);
        check("rst_dldt",    32'(bus.DLDT),    0);
        check("rst_dlen",    32'(bus.DLEN),    0);
        check("rst_busy",    32'(bus.DLBUSY),  0);
        check("rst_done",    32'(bus.DLDONE),  0);
        check("rst_err",     32'(bus.DLERR),   0);
        check("rst_sum",     32'(bus.DLSUM),   0);
        check("rst_corerst", 32'(bus.CORERST), 1);
        rst = 1'b0;
        step();

        // scenario table
        for (int i = 0; i < 8; i++) begin
            build_seq(vt[i].kind);
            apply_load(vt[i].fall_last, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_exp_done", i),    32'(bus.DLDONE),  32'(vt[i].exp_done));
            check($sformatf("tbl%0d_exp_corerst", i), 32'(bus.CORERST), 32'(!vt[i].exp_done));
        end

        // foreign index while the core runs
        build_seq(0);
        apply_load(1'b0, "pre_wi");
        bus.IODL = 1'b1; bus.IOIX = 8'h01;
        step();
        for (int i = 0; i < 8; i++) begin
            bus.IOWR = 1'b1; bus.IOAD = 25'(i); bus.IODT = 8'(i);
            step();
        end
        bus.IOWR = 1'b0; bus.IODL = 1'b0;
        step(); step();
        check("wi_done",     32'(bus.DLDONE),  1);
        check("wi_corerst",  32'(bus.CORERST), 0);
        check("wi_busy",     32'(bus.DLBUSY),  0);
        check("wi_dlen_bad", dlen_bad,         0);
        bus.IOIX = ROMIX;

        // reset mid-load, with a strobe landing in the reset cycle
        model_reset();
        bus.IODL = 1'b1; bus.IOIX = ROMIX;
        step();
        for (int a = 0; a <= 32'h800; a++) begin
            r.ix = ROMIX; r.addr = 25'(a); r.data = 8'($urandom); r.gap = 0;
            bus.IOWR = 1'b1; bus.IOAD = r.addr; bus.IODT = r.data;
            model_write(r);
            step();
        end
        bus.IOAD = 25'h801; bus.IODT = 8'h5A; bus.IOWR = 1'b1; bus.IODL = 1'b0; rst = 1'b1;
        step();
        bus.IOWR = 1'b0;
        check("mrst_corerst", 32'(bus.CORERST), 1);
        check("mrst_busy",    32'(bus.DLBUSY),  0);
        check("mrst_dlen",    32'(bus.DLEN),    0);
        check("mrst_sum",     32'(bus.DLSUM),   0);
        check("mrst_err",     32'(bus.DLERR),   0);
        rst = 1'b0;
        step(); step();
        check("mrst_dlen_bad", dlen_bad, 0);
        check("mrst_dlen_cnt", dlen_seen, m_cnt);
        build_seq(0);
        apply_load(1'b0, "post_rst");

        // randomized loads
        for (int n = 0; n < 3; n++) begin
            mode = $urandom_range(0, 3);
            pos  = $urandom_range(1, IMGI - 2);
            wrq.delete();
            for (int a = 0; a < IMGI; a++) begin
                if (!(mode == 1 && a == pos))
                    push_wr(ROMIX, a, 8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
                if (mode == 2 && a == pos)
                    push_wr(ROMIX, IMGI + $urandom_range(0, 32'h1FE0000), 8'($urandom), 0);
                if (mode == 3 && a == pos)
                    push_wr(8'($urandom_range(1, 255)), $urandom_range(0, IMGI - 1), 8'($urandom), 0);
            end
            apply_load(1'($urandom_range(0, 1)), $sformatf("rnd%0d_m%0d", n, mode));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
